// File: rtl/encode8to3_stream_if.sv
// Handshake bundle for encode8to3_stream.
// slave = encoder side, master = source/sink side.
interface encode8to3_stream_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] out_idx;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       zero;

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_idx,
        output out_valid,
        output out_last,
        output zero
    );

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_idx,
        input  out_valid,
        input  out_last,
        input  zero
    );
endinterface

// File: rtl/encode8to3_stream.sv
// Sequential 8-to-3 encoder: streams the index of each set bit
// of an accepted vector, one beat per handshake, last beat flagged.
module encode8to3_stream #(
    parameter bit PRIO_LOW = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    encode8to3_stream_if.slave bus
);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t     state;
    logic [7:0] mask;
    logic       zero_q;
    logic [2:0] idx;
    logic       onehot;
    logic       accept;
    logic       beat;

    // Priority-encode the pending mask in the configured scan order.
    always_comb begin
        idx = 3'd0;
        if (PRIO_LOW) begin
            for (int i = 7; i >= 0; i--) begin
                if (mask[i]) idx = 3'(i);
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (mask[i]) idx = 3'(i);
            end
        end
    end

    // Exactly one pending bit means the current beat is the last.
    always_comb begin
        onehot = (mask != 8'd0) && ((mask & (mask - 8'd1)) == 8'd0);
    end

    assign accept = bus.in_valid && (state == IDLE);
    assign beat   = (state == SCAN) && bus.out_ready;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == SCAN);
    assign bus.out_idx   = (state == SCAN) ? idx : 3'd0;
    assign bus.out_last  = (state == SCAN) && onehot;
    assign bus.zero      = zero_q;

    // FSM: load vector on accept, retire one bit per output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mask   <= 8'd0;
            zero_q <= 1'b0;
        end else begin
            zero_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (bus.in_data != 8'd0) begin
                            mask  <= bus.in_data;
                            state <= SCAN;
                        end else begin
                            zero_q <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (beat) begin
                        mask <= mask & ~(8'b1 << idx);
                        if (onehot) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encode8to3_stream.sv
// Directed bench for encode8to3_stream in both scan orders.
// Drives #1 after posedge, samples on negedge.
module tb_encode8to3_stream;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    encode8to3_stream_if ifl ();
    encode8to3_stream_if ifh ();

    encode8to3_stream #(.PRIO_LOW(1'b1)) dut_lo (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifl.slave)
    );

    encode8to3_stream #(.PRIO_LOW(1'b0)) dut_hi (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifh.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        ifl.in_valid = 1'b1;
        ifl.in_data = 8'h5A;
        #3;
        checks++;
        if (ifl.in_ready !== 1'b1 || ifl.out_valid !== 1'b0 ||
            ifl.out_idx !== 3'd0 || ifl.out_last !== 1'b0 ||
            ifl.zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_lo rdy=%b vld=%b idx=%0d last=%b zero=%b want 1 0 0 0 0",
                     ifl.in_ready, ifl.out_valid, ifl.out_idx,
                     ifl.out_last, ifl.zero);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ifl.out_valid !== 1'b0 || ifl.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ignores_valid vld=%b rdy=%b want 0 1",
                     ifl.out_valid, ifl.in_ready);
        end
        ifl.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_onehot();
        for (int i = 0; i < 8; i++) begin
            ifl.in_valid = 1'b1;
            ifl.in_data = 8'(1 << i);
            @(posedge clk);
            #1;
            ifl.in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (ifl.out_valid !== 1'b1 || ifl.out_idx !== 3'(i) ||
                ifl.out_last !== 1'b1) begin
                errors++;
                $display("FAIL onehot%0d vld=%b idx=%0d last=%b want 1 %0d 1",
                         i, ifl.out_valid, ifl.out_idx, ifl.out_last, i);
            end
            @(posedge clk);
            #1;
            @(negedge clk);
            checks++;
            if (ifl.out_valid !== 1'b0 || ifl.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL onehot%0d_done vld=%b rdy=%b want 0 1",
                         i, ifl.out_valid, ifl.in_ready);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_multihot_low();
        logic [2:0] exp_idx [4];
        exp_idx = '{3'd0, 3'd2, 3'd5, 3'd7};
        ifl.in_valid = 1'b1;
        ifl.in_data = 8'hA5;
        @(posedge clk);
        #1;
        ifl.in_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            checks++;
            if (ifl.out_valid !== 1'b1 || ifl.out_idx !== exp_idx[b] ||
                ifl.out_last !== (b == 3)) begin
                errors++;
                $display("FAIL a5_low beat%0d vld=%b idx=%0d last=%b want 1 %0d %b",
                         b, ifl.out_valid, ifl.out_idx, ifl.out_last,
                         exp_idx[b], (b == 3));
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checks++;
        if (ifl.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL a5_low_extra vld=%b want 0", ifl.out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_multihot_high();
        logic [2:0] exp_idx [4];
        exp_idx = '{3'd7, 3'd5, 3'd2, 3'd0};
        ifh.in_valid = 1'b1;
        ifh.in_data = 8'hA5;
        @(posedge clk);
        #1;
        ifh.in_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            checks++;
            if (ifh.out_valid !== 1'b1 || ifh.out_idx !== exp_idx[b] ||
                ifh.out_last !== (b == 3)) begin
                errors++;
                $display("FAIL a5_high beat%0d vld=%b idx=%0d last=%b want 1 %0d %b",
                         b, ifh.out_valid, ifh.out_idx, ifh.out_last,
                         exp_idx[b], (b == 3));
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checks++;
        if (ifh.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL a5_high_extra vld=%b want 0", ifh.out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        ifl.out_ready = 1'b0;
        ifl.in_valid = 1'b1;
        ifl.in_data = 8'h81;
        @(posedge clk);
        #1;
        ifl.in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (ifl.out_valid !== 1'b1 || ifl.out_idx !== 3'd0 ||
                ifl.out_last !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d vld=%b idx=%0d last=%b want 1 0 0",
                         c, ifl.out_valid, ifl.out_idx, ifl.out_last);
            end
            @(posedge clk);
            #1;
        end
        ifl.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ifl.out_idx !== 3'd0 || ifl.out_last !== 1'b0) begin
            errors++;
            $display("FAIL bp_beat0 idx=%0d last=%b want 0 0",
                     ifl.out_idx, ifl.out_last);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (ifl.out_valid !== 1'b1 || ifl.out_idx !== 3'd7 ||
            ifl.out_last !== 1'b1) begin
            errors++;
            $display("FAIL bp_beat1 vld=%b idx=%0d last=%b want 1 7 1",
                     ifl.out_valid, ifl.out_idx, ifl.out_last);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int zeros;
        int low_cyc;
        int beats;
        logic [2:0] exp_idx [2];
        exp_idx = '{3'd0, 3'd1};
        zeros = 0;
        low_cyc = 0;
        beats = 0;
        ifl.in_valid = 1'b1;
        ifl.in_data = 8'h00;
        @(posedge clk);
        #1;
        ifl.in_data = 8'h00;
        @(negedge clk);
        if (ifl.zero === 1'b1) zeros++;
        if (ifl.in_ready === 1'b0) low_cyc++;
        @(posedge clk);
        #1;
        ifl.in_data = 8'h03;
        @(negedge clk);
        if (ifl.zero === 1'b1) zeros++;
        if (ifl.in_ready === 1'b0) low_cyc++;
        @(posedge clk);
        #1;
        ifl.in_valid = 1'b0;
        ifl.in_data = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (ifl.zero === 1'b1) zeros++;
            if (ifl.in_ready === 1'b0) low_cyc++;
            if (ifl.out_valid === 1'b1) begin
                checks++;
                if (beats > 1 || ifl.out_idx !== exp_idx[beats[0]] ||
                    ifl.out_last !== (beats == 1)) begin
                    errors++;
                    $display("FAIL b2b_beat%0d idx=%0d last=%b", beats,
                             ifl.out_idx, ifl.out_last);
                end
                beats++;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (zeros != 2) begin
            errors++;
            $display("FAIL b2b_zero_pulses got=%0d want 2", zeros);
        end
        checks++;
        if (beats != 2) begin
            errors++;
            $display("FAIL b2b_beats got=%0d want 2", beats);
        end
        checks++;
        if (low_cyc != 2) begin
            errors++;
            $display("FAIL b2b_ready_low got=%0d want 2", low_cyc);
        end
    endtask

    task automatic test_full();
        int low_cyc;
        int beats;
        low_cyc = 0;
        beats = 0;
        ifl.in_valid = 1'b1;
        ifl.in_data = 8'hFF;
        @(posedge clk);
        #1;
        ifl.in_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ifl.in_ready === 1'b0) low_cyc++;
            if (ifl.out_valid === 1'b1) begin
                checks++;
                if (ifl.out_idx !== 3'(beats) ||
                    ifl.out_last !== (beats == 7)) begin
                    errors++;
                    $display("FAIL full_beat%0d idx=%0d last=%b want %0d %b",
                             beats, ifl.out_idx, ifl.out_last, beats,
                             (beats == 7));
                end
                beats++;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (beats != 8) begin
            errors++;
            $display("FAIL full_beats got=%0d want 8", beats);
        end
        checks++;
        if (low_cyc != 8) begin
            errors++;
            $display("FAIL full_ready_low got=%0d want 8", low_cyc);
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        stray = 0;
        ifl.in_valid = 1'b1;
        ifl.in_data = 8'hF0;
        @(posedge clk);
        #1;
        ifl.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ifl.out_valid !== 1'b1 || ifl.out_idx !== 3'd4) begin
            errors++;
            $display("FAIL rmid_first vld=%b idx=%0d want 1 4",
                     ifl.out_valid, ifl.out_idx);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ifl.in_ready !== 1'b1 || ifl.out_valid !== 1'b0 ||
            ifl.out_idx !== 3'd0 || ifl.out_last !== 1'b0 ||
            ifl.zero !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async rdy=%b vld=%b idx=%0d last=%b zero=%b want 1 0 0 0 0",
                     ifl.in_ready, ifl.out_valid, ifl.out_idx,
                     ifl.out_last, ifl.zero);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (ifl.out_valid !== 1'b0) stray++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL rmid_stray got=%0d want 0", stray);
        end
        ifl.in_valid = 1'b1;
        ifl.in_data = 8'h02;
        @(posedge clk);
        #1;
        ifl.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ifl.out_valid !== 1'b1 || ifl.out_idx !== 3'd1 ||
            ifl.out_last !== 1'b1) begin
            errors++;
            $display("FAIL rmid_next vld=%b idx=%0d last=%b want 1 1 1",
                     ifl.out_valid, ifl.out_idx, ifl.out_last);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ifl.in_valid = 1'b0;
        ifl.in_data = 8'h00;
        ifl.out_ready = 1'b1;
        ifh.in_valid = 1'b0;
        ifh.in_data = 8'h00;
        ifh.out_ready = 1'b1;
        test_reset();
        test_onehot();
        test_multihot_low();
        test_multihot_high();
        test_backpressure();
        test_back_to_back();
        test_full();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
